cr_bmu_ibus_vec_resp: RTL and testbench



---
 rtl/cr_bmu_ibus_pkg.sv | 22 ++
 rtl/cr_bmu_ibus_wdog.sv | 27 ++
 rtl/cr_bmu_ibus_vec_resp.sv | 119 +++++++++++
 tb/tb_cr_bmu_ibus_vec_resp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_bmu_ibus_pkg.sv
// rtl/cr_bmu_ibus_pkg.sv - shared state encoding and address-window helper for the ibus responder
// Optional watchdog build macro: CR_IBUS_RESP_TIMEOUT_EN

package cr_bmu_ibus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCESS = 2'd2,
    DRAIN  = 2'd3
  } ibus_state_e;

  // Offset compare so addresses below base wrap to a large value and fail.
  function automatic logic in_win(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] size);
    logic [31:0] ofs;
    ofs = addr - base;
    return (ofs < size);
  endfunction

endpackage

// File: rtl/cr_bmu_ibus_wdog.sv
// rtl/cr_bmu_ibus_wdog.sv - response watchdog counter, built only with CR_IBUS_RESP_TIMEOUT_EN

module cr_bmu_ibus_wdog #(
  parameter int TMO_CYC = 16
) (
  input  logic misc_clk,
  input  logic cpurst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge misc_clk) begin
    if (cpurst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/cr_bmu_ibus_vec_resp.sv
// rtl/cr_bmu_ibus_vec_resp.sv - single-outstanding ibus responder with window check and memory forwarding
// Optional response watchdog: define CR_IBUS_RESP_TIMEOUT_EN

module cr_bmu_ibus_vec_resp
  import cr_bmu_ibus_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0001_0000,
  parameter int          TMO_CYC   = 16
) (
  input  logic              misc_clk,
  input  logic              cpurst,
  input  logic              ibus_req,
  input  logic [ADDR_W-1:0] ibus_addr,
  input  logic              iu_bmu_vec_redirect,
  output logic              bmu_xx_ibus_grnt,
  output logic              bmu_xx_ibus_data_vld,
  output logic              bmu_xx_ibus_acc_err,
  output logic [DATA_W-1:0] bmu_xx_ibus_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvld,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  ibus_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              vld_q, err_q, vld_d, err_d;
  logic [DATA_W-1:0] rdata_q;
  logic              grnt, mem_req_d, addr_ok, wdog_expire;

  assign addr_ok = in_win(32'(addr_q), BASE_ADDR, WIN_SIZE) && (addr_q[1:0] == 2'b00);

`ifdef CR_IBUS_RESP_TIMEOUT_EN
  cr_bmu_ibus_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .misc_clk (misc_clk),
    .cpurst   (cpurst),
    .clr      (state_q != ACCESS),
    .en       (state_q == ACCESS),
    .expire   (wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grnt      = 1'b0;
    mem_req_d = 1'b0;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Hold off the next grant while the previous response pulse is on the bus.
        grnt = ibus_req && !iu_bmu_vec_redirect && !vld_q && !err_q;
        if (grnt) state_d = CHECK;
      end
      CHECK: begin
        if (iu_bmu_vec_redirect) begin
          state_d = IDLE;
        end else if (!addr_ok) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          mem_req_d = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (iu_bmu_vec_redirect) begin
          state_d = (mem_rvld || mem_err) ? IDLE : DRAIN;
        end else if (mem_err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (mem_rvld) begin
          vld_d   = 1'b1;
          state_d = IDLE;
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvld || mem_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge misc_clk) begin
    if (cpurst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grnt) addr_q <= ibus_addr;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= vld_d ? mem_rdata : '0;
    end
  end

  // Combinational strobes are masked so every output is quiet while reset is held.
  assign bmu_xx_ibus_grnt     = grnt && !cpurst;
  assign mem_req              = mem_req_d && !cpurst;
  assign bmu_xx_ibus_data_vld = vld_q;
  assign bmu_xx_ibus_acc_err  = err_q;
  assign bmu_xx_ibus_rdata    = rdata_q;
  assign mem_addr             = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_cr_bmu_ibus_vec_resp.sv
// tb/tb_cr_bmu_ibus_vec_resp.sv - self-checking bench for cr_bmu_ibus_vec_resp

module tb_cr_bmu_ibus_vec_resp;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] WIN  = 32'h0001_0000;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          kind;
    logic [31:0] data;
    int          exp_mreq;
    int          exp_resp;
    int          exp_ofs;
  } vec_t;

  logic        misc_clk = 1'b0;
  logic        cpurst = 1'b1;
  logic        ibus_req = 1'b0;
  logic [31:0] ibus_addr = '0;
  logic        iu_bmu_vec_redirect = 1'b0;
  logic        bmu_xx_ibus_grnt, bmu_xx_ibus_data_vld, bmu_xx_ibus_acc_err;
  logic [31:0] bmu_xx_ibus_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvld = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 misc_clk = ~misc_clk;

  cr_bmu_ibus_vec_resp #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .WIN_SIZE(WIN), .TMO_CYC(16)
  ) dut (
    .misc_clk             (misc_clk),
    .cpurst               (cpurst),
    .ibus_req             (ibus_req),
    .ibus_addr            (ibus_addr),
    .iu_bmu_vec_redirect  (iu_bmu_vec_redirect),
    .bmu_xx_ibus_grnt     (bmu_xx_ibus_grnt),
    .bmu_xx_ibus_data_vld (bmu_xx_ibus_data_vld),
    .bmu_xx_ibus_acc_err  (bmu_xx_ibus_acc_err),
    .bmu_xx_ibus_rdata    (bmu_xx_ibus_rdata),
    .mem_req              (mem_req),
    .mem_addr             (mem_addr),
    .mem_rvld             (mem_rvld),
    .mem_rdata            (mem_rdata),
    .mem_err              (mem_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    ibus_req = 1'b0;
    iu_bmu_vec_redirect = 1'b0;
    mem_rvld = 1'b0;
    mem_err = 1'b0;
  endtask

  // One transaction from a quiet IDLE; a small memory model answers each mem_req after v.lat cycles.
  task automatic run_txn(input vec_t v, input string nm);
    int t_g = -1, n_mreq = 0, t_mreq = -1, t_rsp = -1000;
    int n_pulse = 0, resp = 0, t_resp = -1, rd_bad = 0;
    logic [31:0] ma = '0, rd = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge misc_clk);
      ibus_req = (t_g < 0);
      ibus_addr = v.addr;
      iu_bmu_vec_redirect = 1'b0;
      mem_rvld = (c == t_rsp) && (v.kind != 1);
      mem_err = (c == t_rsp) && (v.kind != 0);
      mem_rdata = (c == t_rsp) ? v.data : $urandom;
      #1;
      if (bmu_xx_ibus_grnt && t_g < 0) t_g = c;
      if (mem_req) begin n_mreq++; t_mreq = c; ma = mem_addr; t_rsp = c + v.lat; end
      if (bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err) begin
        n_pulse++;
        resp = bmu_xx_ibus_data_vld ? 1 : 2;
        t_resp = c;
        if (bmu_xx_ibus_data_vld) rd = bmu_xx_ibus_rdata;
      end
      if (!bmu_xx_ibus_data_vld && bmu_xx_ibus_rdata != 0) rd_bad++;
    end
    idle_in();
    chk({nm, "_grant_cycle"}, t_g, 0);
    chk({nm, "_mem_req_count"}, n_mreq, v.exp_mreq);
    if (v.exp_mreq != 0) begin
      chk({nm, "_mem_req_cycle"}, t_mreq - t_g, 1);
      chk({nm, "_mem_addr"}, ma, v.addr);
    end
    chk({nm, "_pulse_count"}, n_pulse, (v.exp_resp != 0) ? 1 : 0);
    chk({nm, "_resp_kind"}, resp, v.exp_resp);
    if (v.exp_resp != 0) chk({nm, "_resp_latency"}, t_resp - t_g, v.exp_ofs);
    if (v.exp_resp == 1) chk({nm, "_rdata"}, rd, v.data);
    chk({nm, "_rdata_idle_zero"}, rd_bad, 0);
  endtask

  vec_t tbl[7];

  initial begin
    int rst_or, pre, g2, t_v, t_m2, g0, n_p, t_e, rsp;
    logic [31:0] rd2;
    int gr[$];
    int mr[$];
    int tv[$];
    vec_t v;

    // kind: 0 = mem_rvld, 1 = mem_err, 2 = both in the same cycle
    tbl[0] = '{32'h0000_0040, 3, 0, 32'hDEAD_BEEF, 1, 1, 5};
    tbl[1] = '{32'h0001_0000, 1, 0, 32'h0,         0, 2, 2};
    tbl[2] = '{32'h0000_0042, 1, 0, 32'h0,         0, 2, 2};
    tbl[3] = '{32'h0000_0080, 2, 2, 32'h1111_2222, 1, 2, 4};
    tbl[4] = '{32'h0000_0100, 1, 1, 32'h3333_4444, 1, 2, 3};
    tbl[5] = '{32'h0000_FFFC, 1, 0, 32'h1234_5678, 1, 1, 3};
    tbl[6] = '{32'hFFFF_FFFC, 1, 0, 32'h0,         0, 2, 2};

    // Reset state, with a request pending to prove grant is masked.
    cpurst = 1'b1;
    ibus_req = 1'b1;
    ibus_addr = 32'h40;
    repeat (3) @(negedge misc_clk);
    #1;
    chk("rst_grnt", bmu_xx_ibus_grnt, 0);
    chk("rst_data_vld", bmu_xx_ibus_data_vld, 0);
    chk("rst_acc_err", bmu_xx_ibus_acc_err, 0);
    chk("rst_rdata", bmu_xx_ibus_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge misc_clk);
    cpurst = 1'b0;
    idle_in();

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomized transactions against a transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int cls;
      logic legal;
      cls = $urandom_range(0, 3);
      v.addr = 32'($urandom_range(0, 16383)) << 2;
      if (cls == 1) v.addr = v.addr | 32'($urandom_range(1, 3));
      if (cls == 2) v.addr = 32'h0001_0000 + ($urandom & 32'h0FFF_FFFC);
      v.lat = $urandom_range(1, 6);
      v.kind = $urandom_range(0, 2);
      v.data = $urandom;
      legal = (64'(v.addr) >= 64'(BASE)) && (64'(v.addr) < 64'(BASE) + 64'(WIN)) && (v.addr % 4 == 0);
      v.exp_mreq = legal ? 1 : 0;
      v.exp_resp = !legal ? 2 : (v.kind == 0 ? 1 : 2);
      v.exp_ofs = !legal ? 2 : v.lat + 2;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Redirect in ACCESS, late response drained, next request held until after it.
    g2 = -1; pre = 0; t_v = -1; t_m2 = -1; g0 = 0; rd2 = '0;
    for (int c = 0; c < 15; c++) begin
      @(negedge misc_clk);
      ibus_req = (c == 0) || (c >= 3 && g2 < 0);
      ibus_addr = (c == 0) ? 32'h40 : 32'h44;
      iu_bmu_vec_redirect = (c == 2);
      mem_rvld = (c == 4) || (t_m2 >= 0 && c == t_m2 + 1);
      mem_rdata = (c == 4) ? 32'hBAD0_BAD0 : 32'hA5A5_0001;
      mem_err = 1'b0;
      #1;
      if (c == 0) g0 = int'(bmu_xx_ibus_grnt);
      if (c >= 3 && bmu_xx_ibus_grnt && g2 < 0) g2 = c;
      if (mem_req && c >= 3) t_m2 = c;
      if ((bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err) && c < 5) pre++;
      if (bmu_xx_ibus_data_vld && c >= 5) begin t_v = c; rd2 = bmu_xx_ibus_rdata; end
    end
    idle_in();
    chk("redir_first_grant", g0, 1);
    chk("redir_no_response", pre, 0);
    chk("redir_regrant_cycle", g2, 5);
    chk("redir_next_vld_cycle", t_v, 8);
    chk("redir_next_rdata", rd2, 32'hA5A5_0001);

    // Back-to-back reads with the request held high.
    rsp = -1;
    for (int c = 0; c < 11; c++) begin
      @(negedge misc_clk);
      ibus_req = (gr.size() < 2);
      ibus_addr = (gr.size() == 0) ? 32'h40 : 32'h44;
      mem_rvld = (c == rsp);
      mem_rdata = 32'h1000 + 32'(c);
      #1;
      if (bmu_xx_ibus_grnt) gr.push_back(c);
      if (mem_req) begin mr.push_back(c); rsp = c + 1; end
      if (bmu_xx_ibus_data_vld) tv.push_back(c);
    end
    idle_in();
    chk("b2b_grant_count", gr.size(), 2);
    chk("b2b_second_grant", gr[1], 4);
    chk("b2b_mem_req_count", mr.size(), 2);
    chk("b2b_second_mem_req", mr[1], 5);
    chk("b2b_first_vld", tv[0], 3);

    // Watchdog: no memory response after the request.
    n_p = 0; t_e = -1;
`ifdef CR_IBUS_RESP_TIMEOUT_EN
    for (int c = 0; c < 30; c++) begin
      @(negedge misc_clk);
      ibus_req = (c == 0);
      ibus_addr = 32'h40;
      mem_rvld = (c == 24);
      #1;
      if (bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err) n_p++;
      if (bmu_xx_ibus_acc_err && t_e < 0) t_e = c;
    end
    idle_in();
    chk("tmo_err_cycle", t_e, 18);
    chk("tmo_pulse_count", n_p, 1);
`else
    for (int c = 0; c < 110; c++) begin
      @(negedge misc_clk);
      ibus_req = (c == 0);
      ibus_addr = 32'h40;
      mem_rvld = 1'b0;
      #1;
      if (bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err) n_p++;
    end
    idle_in();
    chk("no_tmo_pulses", n_p, 0);
`endif

    // Reset while in ACCESS, then a stray mem_rvld.
    @(negedge misc_clk);
    cpurst = 1'b1;
    @(negedge misc_clk);
    cpurst = 1'b0;
    rst_or = 0; pre = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge misc_clk);
      cpurst = (c == 3) || (c == 4);
      ibus_req = (c == 0);
      ibus_addr = 32'h40;
      mem_rvld = (c == 5);
      mem_rdata = 32'hCAFE_F00D;
      #1;
      if (c == 4) rst_or = int'(bmu_xx_ibus_grnt || bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err || mem_req
                                || bmu_xx_ibus_rdata != 0 || mem_addr != 0);
      if (c >= 5 && (bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err)) pre++;
    end
    idle_in();
    cpurst = 1'b0;
    chk("rst_mid_outputs", rst_or, 0);
    chk("rst_mid_no_pulse", pre, 0);
    v = '{32'h0000_0200, 2, 0, 32'h5A5A_C3C3, 1, 1, 4};
    run_txn(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
